// File: rtl/tracer_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tracer_anim_ctrl
//
// Once-per-frame animation and skill-timer sequencer for the player sprite.
// All state advances only on i_frame_tick, so the animation rate follows the
// display frame rate rather than the system clock.
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | standing still, pose 0
// RUN   | exactly one movement key held, pose cycles 1,2,3,0,...
// AIR   | airborne or jump just taken, pose 4
//
// Ports
//   i_clk              system clock
//   i_reset_n          asynchronous active-low reset
//   i_frame_tick       one-clock pulse per video frame
//   i_move_left/right  held movement keys (level)
//   i_on_ground        character resting on a platform (level)
//   i_jump_req         jump request pulse (any width)
//   i_shift_req        shift skill request pulse
//   i_kick_req         kick skill request pulse
//   i_ult_req          ultimate skill request pulse
//   o_chara_direction  1 = facing right, 0 = facing left
//   o_figure           0 idle/run0, 1..3 run phases, 4 jump
//   o_count_s/k/l      skill counters, 1023 = idle
//   o_ready_s/k/l      skill may be triggered on the next tick
// -----------------------------------------------------------------------------
module tracer_anim_ctrl #(
    parameter int RUN_DIV = 6,
    parameter int S_LEN   = 8,
    parameter int S_CD    = 60,
    parameter int K_LEN   = 10,
    parameter int K_CD    = 30,
    parameter int L_LEN   = 75,
    parameter int L_CD    = 600
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_frame_tick,
    input  logic       i_move_left,
    input  logic       i_move_right,
    input  logic       i_on_ground,
    input  logic       i_jump_req,
    input  logic       i_shift_req,
    input  logic       i_kick_req,
    input  logic       i_ult_req,
    output logic       o_chara_direction,
    output logic [2:0] o_figure,
    output logic [9:0] o_count_s,
    output logic [9:0] o_count_k,
    output logic [9:0] o_count_l,
    output logic       o_ready_s,
    output logic       o_ready_k,
    output logic       o_ready_l
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_AIR  = 2'd2;

    localparam logic [2:0] FIG_IDLE = 3'd0;
    localparam logic [2:0] FIG_RUN1 = 3'd1;
    localparam logic [2:0] FIG_RUN3 = 3'd3;
    localparam logic [2:0] FIG_JUMP = 3'd4;

    localparam logic [9:0] CNT_IDLE = 10'd1023;

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    // A cooldown shorter than its active window would let a skill restart
    // while still active, so the effective cooldown is never below the window.
    localparam int S_CD_EFF = (S_CD < S_LEN) ? S_LEN : S_CD;
    localparam int K_CD_EFF = (K_CD < K_LEN) ? K_LEN : K_CD;
    localparam int L_CD_EFF = (L_CD < L_LEN) ? L_LEN : L_CD;

    localparam logic [9:0] S_CD_V = 10'(S_CD_EFF);
    localparam logic [9:0] K_CD_V = 10'(K_CD_EFF);
    localparam logic [9:0] L_CD_V = 10'(L_CD_EFF);

    logic [1:0]       r_state;
    logic [2:0]       r_figure;
    logic [DIV_W-1:0] r_div;
    logic             r_dir;

    logic             r_jump_lat;
    logic             r_shift_lat;
    logic             r_kick_lat;
    logic             r_ult_lat;

    logic [9:0]       r_cnt_s;
    logic [9:0]       r_cnt_k;
    logic [9:0]       r_cnt_l;

    logic             w_jump_eff;
    logic             w_shift_eff;
    logic             w_kick_eff;
    logic             w_ult_eff;
    logic             w_one_dir;
    logic             w_go_air;

    logic [1:0]       w_state_nxt;
    logic [2:0]       w_figure_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_dir_nxt;

    // -------------------------------------------------------------------------
    // Request latches: a pulse anywhere between ticks is remembered, and a
    // pulse coincident with the tick is folded in combinationally so that the
    // tick itself sees it. Every tick empties the latches.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_jump_lat  <= 1'b0;
            r_shift_lat <= 1'b0;
            r_kick_lat  <= 1'b0;
            r_ult_lat   <= 1'b0;
        end else if (i_frame_tick) begin
            r_jump_lat  <= 1'b0;
            r_shift_lat <= 1'b0;
            r_kick_lat  <= 1'b0;
            r_ult_lat   <= 1'b0;
        end else begin
            r_jump_lat  <= r_jump_lat  | i_jump_req;
            r_shift_lat <= r_shift_lat | i_shift_req;
            r_kick_lat  <= r_kick_lat  | i_kick_req;
            r_ult_lat   <= r_ult_lat   | i_ult_req;
        end
    end

    assign w_jump_eff  = r_jump_lat  | i_jump_req;
    assign w_shift_eff = r_shift_lat | i_shift_req;
    assign w_kick_eff  = r_kick_lat  | i_kick_req;
    assign w_ult_eff   = r_ult_lat   | i_ult_req;

    // -------------------------------------------------------------------------
    // Facing and pose
    // -------------------------------------------------------------------------
    assign w_one_dir = i_move_left ^ i_move_right;

    // A jump latch only launches from the ground outside AIR: no double jump.
    assign w_go_air = ~i_on_ground |
                      (w_jump_eff & i_on_ground & (r_state != ST_AIR));

    always_comb begin
        w_dir_nxt = r_dir;
        if (i_move_right && !i_move_left) begin
            w_dir_nxt = 1'b1;
        end else if (i_move_left && !i_move_right) begin
            w_dir_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_figure_nxt = r_figure;
        w_div_nxt    = r_div;
        if (w_go_air) begin
            w_state_nxt  = ST_AIR;
            w_figure_nxt = FIG_JUMP;
            w_div_nxt    = '0;
        end else if (w_one_dir) begin
            w_state_nxt = ST_RUN;
            if (r_state != ST_RUN) begin
                w_figure_nxt = FIG_RUN1;
                w_div_nxt    = '0;
            end else if (r_div == DIV_LAST) begin
                w_div_nxt    = '0;
                w_figure_nxt = (r_figure == FIG_RUN3) ? FIG_IDLE
                                                      : r_figure + 3'd1;
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end else begin
            w_state_nxt  = ST_IDLE;
            w_figure_nxt = FIG_IDLE;
            w_div_nxt    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_figure <= FIG_IDLE;
            r_div    <= '0;
            r_dir    <= 1'b1;
        end else if (i_frame_tick) begin
            r_state  <= w_state_nxt;
            r_figure <= w_figure_nxt;
            r_div    <= w_div_nxt;
            r_dir    <= w_dir_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Skill counters: accepted request restarts at 0, otherwise count up one
    // per frame and park at 1023 (the idle marker) instead of wrapping.
    // -------------------------------------------------------------------------
    function automatic logic [9:0] f_skill_nxt(
        input logic [9:0] c,
        input logic       req,
        input logic [9:0] cd
    );
        logic [9:0] n;
        if (req && ((c >= cd) || (c == CNT_IDLE))) begin
            n = '0;
        end else if (c == CNT_IDLE) begin
            n = c;
        end else begin
            n = c + 10'd1;
        end
        return n;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt_s <= CNT_IDLE;
            r_cnt_k <= CNT_IDLE;
            r_cnt_l <= CNT_IDLE;
        end else if (i_frame_tick) begin
            r_cnt_s <= f_skill_nxt(r_cnt_s, w_shift_eff, S_CD_V);
            r_cnt_k <= f_skill_nxt(r_cnt_k, w_kick_eff,  K_CD_V);
            r_cnt_l <= f_skill_nxt(r_cnt_l, w_ult_eff,   L_CD_V);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_chara_direction = r_dir;
    assign o_figure          = r_figure;
    assign o_count_s         = r_cnt_s;
    assign o_count_k         = r_cnt_k;
    assign o_count_l         = r_cnt_l;

    assign o_ready_s = (r_cnt_s >= S_CD_V) | (r_cnt_s == CNT_IDLE);
    assign o_ready_k = (r_cnt_k >= K_CD_V) | (r_cnt_k == CNT_IDLE);
    assign o_ready_l = (r_cnt_l >= L_CD_V) | (r_cnt_l == CNT_IDLE);

endmodule
